// File: rtl/nios_system_nios2_qysys_0_cpu_debug_scan_master.sv
// JTAG scan master for the Nios II debug slave's virtual-JTAG port: one IR select
// plus one DR scan per accepted command, returning the captured DR bits.
module nios_system_nios2_qysys_0_cpu_debug_scan_master #(
   parameter int DR_WIDTH = 38,
   parameter int IR_WIDTH = 2,
   parameter int TCK_HALF = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [IR_WIDTH-1:0] cmd_ir,
   input  logic [DR_WIDTH-1:0] cmd_dr,
   output logic                rsp_valid,
   output logic [DR_WIDTH-1:0] rsp_dr,
   output logic [IR_WIDTH-1:0] rsp_ir_out,
   output logic                vji_tck,
   output logic                vji_tdi,
   input  logic                vji_tdo,
   output logic [IR_WIDTH-1:0] vji_ir_in,
   input  logic [IR_WIDTH-1:0] vji_ir_out,
   output logic                vji_uir,
   output logic                vji_cdr,
   output logic                vji_sdr,
   output logic                vji_udr,
   output logic                vji_rti
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_UIR   = 3'd1;
   localparam logic [2:0] S_CDR   = 3'd2;
   localparam logic [2:0] S_SHIFT = 3'd3;
   localparam logic [2:0] S_UDR   = 3'd4;
   localparam logic [2:0] S_RTI   = 3'd5;

   localparam int HW = (TCK_HALF > 1) ? $clog2(TCK_HALF) : 1;
   localparam int BW = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
   localparam logic [HW-1:0] HALF_LAST = HW'(TCK_HALF - 1);
   localparam logic [HW-1:0] HALF_PRE  = HW'((TCK_HALF > 1) ? TCK_HALF - 2 : 0);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DR_WIDTH - 1);

   logic [2:0]          state;
   logic [HW-1:0]       half_cnt;
   logic                phase;
   logic [BW-1:0]       bit_cnt;
   logic [DR_WIDTH-1:0] shift_in;
   logic [DR_WIDTH-1:0] capture;
   logic [IR_WIDTH-1:0] ir_lat;
   logic                ready_en;
   logic                busy, half_end, low_end, period_end, pre_end, accept;

   assign busy       = (state != S_IDLE);
   assign half_end   = (half_cnt == HALF_LAST);
   assign low_end    = busy && !phase && half_end;
   assign period_end = busy && phase && half_end;
   // Cycle before the final cycle of a period; rsp_valid is registered off it
   assign pre_end    = (TCK_HALF == 1) ? low_end : (busy && phase && (half_cnt == HALF_PRE));

   // The last RTI cycle doubles as the accept slot so back-to-back scans leave no idle gap
   assign cmd_ready  = ready_en && (!busy || rsp_valid);
   assign accept     = cmd_valid && cmd_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         half_cnt   <= '0;
         phase      <= 1'b0;
         rsp_valid  <= 1'b0;
         ready_en   <= 1'b0;
         rsp_dr     <= '0;
         rsp_ir_out <= '0;
      end else begin
         ready_en  <= 1'b1;
         rsp_valid <= (state == S_RTI) && pre_end;
         if (busy) begin
            if (half_end) begin
               half_cnt <= '0;
               phase    <= !phase;
            end else begin
               half_cnt <= half_cnt + HW'(1);
            end
         end
         if ((state == S_UIR) && low_end)
            rsp_ir_out <= vji_ir_out;
         if ((state == S_RTI) && pre_end)
            rsp_dr <= capture;
         if (accept) begin
            state    <= S_UIR;
            half_cnt <= '0;
            phase    <= 1'b0;
         end else if (period_end) begin
            case (state)
               S_UIR:   state <= S_CDR;
               S_CDR:   state <= S_SHIFT;
               S_SHIFT: state <= (bit_cnt == BIT_LAST) ? S_UDR : S_SHIFT;
               S_UDR:   state <= S_RTI;
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   // tdo is taken just before the tck rising edge, when the slave shifts
   always_ff @(posedge clk) begin
      if (accept) begin
         ir_lat   <= cmd_ir;
         shift_in <= cmd_dr;
         bit_cnt  <= '0;
      end else begin
         if ((state == S_SHIFT) && low_end)
            capture <= {vji_tdo, capture[DR_WIDTH-1:1]};
         if ((state == S_SHIFT) && period_end) begin
            shift_in <= shift_in >> 1;
            if (bit_cnt != BIT_LAST)
               bit_cnt <= bit_cnt + BW'(1);
         end
      end
   end

   assign vji_tck   = busy && phase;
   assign vji_tdi   = (state == S_SHIFT) && shift_in[0];
   assign vji_ir_in = busy ? ir_lat : '0;
   assign vji_uir   = (state == S_UIR);
   assign vji_cdr   = (state == S_CDR);
   assign vji_sdr   = (state == S_SHIFT);
   assign vji_udr   = (state == S_UDR);
   assign vji_rti   = (state == S_RTI);

endmodule

// File: tb/tb_nios_system_nios2_qysys_0_cpu_debug_scan_master.sv
// Bench for the debug scan master: two instances (TCK_HALF=2 and 1) each driving a
// right-shift 38-bit slave model that captures a chosen value and records its state at udr.
module tb_nios_system_nios2_qysys_0_cpu_debug_scan_master;

   localparam int DRW = 38;
   localparam int IRW = 2;

   typedef struct {
      logic [IRW-1:0] ir;
      logic [DRW-1:0] dr;
      logic [DRW-1:0] cap;
      logic [DRW-1:0] exp_rsp;
      logic [DRW-1:0] exp_hold;
   } vec_t;

   logic clk;
   logic [1:0] rst, cmd_valid, cmd_ready, rsp_valid, tck, tdi, tdo, uir, cdr, sdr, udr, rti;
   logic [1:0][IRW-1:0] cmd_ir, rsp_ir_out, ir_in, ir_out;
   logic [1:0][DRW-1:0] cmd_dr, rsp_dr, cap_val, sr, held;
   logic [1:0] ptck_m;
   int udr_cnt [2];

   int checks = 0;
   int errors = 0;
   int lat, viol, n_uir, n_cdr, n_sdr, n_udr, n_rti;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   nios_system_nios2_qysys_0_cpu_debug_scan_master #(.DR_WIDTH(DRW), .IR_WIDTH(IRW), .TCK_HALF(2)) dut_a (
      .clk(clk), .reset(rst[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
      .cmd_ir(cmd_ir[0]), .cmd_dr(cmd_dr[0]), .rsp_valid(rsp_valid[0]), .rsp_dr(rsp_dr[0]),
      .rsp_ir_out(rsp_ir_out[0]), .vji_tck(tck[0]), .vji_tdi(tdi[0]), .vji_tdo(tdo[0]),
      .vji_ir_in(ir_in[0]), .vji_ir_out(ir_out[0]), .vji_uir(uir[0]), .vji_cdr(cdr[0]),
      .vji_sdr(sdr[0]), .vji_udr(udr[0]), .vji_rti(rti[0]));

   nios_system_nios2_qysys_0_cpu_debug_scan_master #(.DR_WIDTH(DRW), .IR_WIDTH(IRW), .TCK_HALF(1)) dut_b (
      .clk(clk), .reset(rst[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
      .cmd_ir(cmd_ir[1]), .cmd_dr(cmd_dr[1]), .rsp_valid(rsp_valid[1]), .rsp_dr(rsp_dr[1]),
      .rsp_ir_out(rsp_ir_out[1]), .vji_tck(tck[1]), .vji_tdi(tdi[1]), .vji_tdo(tdo[1]),
      .vji_ir_in(ir_in[1]), .vji_ir_out(ir_out[1]), .vji_uir(uir[1]), .vji_cdr(cdr[1]),
      .vji_sdr(sdr[1]), .vji_udr(udr[1]), .vji_rti(rti[1]));

   // Slave model: acts on each tck rising edge, seen mid-cycle
   assign ir_out = {2'b10, 2'b10};
   assign tdo    = {sr[1][0], sr[0][0]};

   always @(negedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (tck[g] && !ptck_m[g]) begin
            if (cdr[g])
               sr[g] <= cap_val[g];
            else if (sdr[g])
               sr[g] <= {tdi[g], sr[g][DRW-1:1]};
            if (udr[g]) begin
               udr_cnt[g] <= udr_cnt[g] + 1;
               held[g]    <= sr[g];
            end
         end
         ptck_m[g] <= tck[g];
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input int g);
      int w = 0;
      while (!cmd_ready[g] && w < 20) begin
         step();
         w++;
      end
      check("cmd_ready_wait", 64'(cmd_ready[g]), 64'd1);
   endtask

   task automatic start(input int g, input logic [IRW-1:0] ir, input logic [DRW-1:0] dr,
                        input logic [DRW-1:0] cap);
      wait_ready(g);
      cap_val[g]   = cap;
      cmd_ir[g]    = ir;
      cmd_dr[g]    = dr;
      cmd_valid[g] = 1'b1;
      step();
      cmd_valid[g] = 1'b0;
   endtask

   // Walks one scan from its first cycle to the rsp_valid cycle, tallying waveform faults
   task automatic monitor(input int g, input int half, input logic [IRW-1:0] ir);
      logic       ptck;
      logic [5:0] psig, sig;
      int         run;
      ptck = 1'b0; psig = '0; run = 0;
      viol = 0; lat = 0;
      n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0; n_rti = 0;
      for (int c = 1; c <= 400; c++) begin
         sig = {tdi[g], uir[g], cdr[g], sdr[g], udr[g], rti[g]};
         if ($countones(sig[4:0]) != 1) viol++;
         if (ir_in[g] != ir) viol++;
         if (cmd_ready[g] != rsp_valid[g]) viol++;
         if (tck[g] && (sig != psig)) viol++;
         if (tck[g] == ptck) begin
            run++;
         end else begin
            if (run != half) viol++;
            run = 1;
            if (tck[g]) begin
               if (uir[g]) n_uir++;
               if (cdr[g]) n_cdr++;
               if (sdr[g]) n_sdr++;
               if (udr[g]) n_udr++;
               if (rti[g]) n_rti++;
            end
         end
         ptck = tck[g];
         psig = sig;
         if (rsp_valid[g]) begin
            lat = c;
            break;
         end
         step();
      end
      if (run != half) viol++;
   endtask

   task automatic scan_check(input int g, input int half, input logic [IRW-1:0] ir,
                             input logic [DRW-1:0] dr, input logic [DRW-1:0] cap,
                             input logic [DRW-1:0] exp_rsp, input logic [DRW-1:0] exp_hold);
      int udr0;
      udr0 = udr_cnt[g];
      start(g, ir, dr, cap);
      monitor(g, half, ir);
      check("latency", 64'(lat), 64'((DRW + 4) * 2 * half));
      check("rsp_dr", 64'(rsp_dr[g]), 64'(exp_rsp));
      check("rsp_ir_out", 64'(rsp_ir_out[g]), 64'(2'b10));
      check("waveform_faults", 64'(viol), 64'd0);
      check("sdr_periods", 64'(n_sdr), 64'(DRW));
      check("uir_cdr_udr_rti_periods", {32'd0, 8'(n_uir), 8'(n_cdr), 8'(n_udr), 8'(n_rti)}, 64'h01010101);
      step();
      check("after_rsp valid/ready/tck/ir_in", {59'd0, rsp_valid[g], cmd_ready[g], tck[g], ir_in[g]}, 64'b01000);
      check("rsp_dr_held", 64'(rsp_dr[g]), 64'(exp_rsp));
      check("slave_at_udr", 64'(held[g]), 64'(exp_hold));
      check("udr_pulses", 64'(udr_cnt[g] - udr0), 64'd1);
   endtask

   initial begin
      vec_t           vecs [4];
      logic [63:0]    r;
      logic [IRW-1:0] rir;
      logic [DRW-1:0] rdr, rcap, cap_a, cap_b, dr_a, dr_b;
      int             lat1, udr0, seen;

      vecs[0] = '{2'b01, 38'h2A5555AAAA, 38'h3F00001234, 38'h3F00001234, 38'h2A5555AAAA};
      vecs[1] = '{2'b00, 38'h0000000000, 38'h3FFFFFFFFF, 38'h3FFFFFFFFF, 38'h0000000000};
      vecs[2] = '{2'b11, 38'h3FFFFFFFFF, 38'h0000000000, 38'h0000000000, 38'h3FFFFFFFFF};
      vecs[3] = '{2'b10, 38'h1555555555, 38'h2AAAAAAAAA, 38'h2AAAAAAAAA, 38'h1555555555};

      rst = 2'b11; cmd_valid = '0; cmd_ir = '0; cmd_dr = '0; cap_val = '0;
      repeat (5) step();
      check("reset vji outputs", {55'd0, tck[0], tdi[0], ir_in[0], uir[0], cdr[0], sdr[0], udr[0], rti[0]}, 64'd0);
      check("reset cmd_ready/rsp_valid", {62'd0, cmd_ready[0], rsp_valid[0]}, 64'd0);
      check("reset rsp_dr", 64'(rsp_dr[0]), 64'd0);
      check("reset rsp_ir_out", 64'(rsp_ir_out[0]), 64'd0);
      check("reset b outputs", {59'd0, tck[1], uir[1], cmd_ready[1], rsp_valid[1], sdr[1]}, 64'd0);
      rst = 2'b00;
      step();
      check("post-reset cmd_ready/rsp_valid", {62'd0, cmd_ready[0], rsp_valid[0]}, 64'b10);
      check("post-reset b cmd_ready", 64'(cmd_ready[1]), 64'd1);

      for (int i = 0; i < 4; i++)
         scan_check(0, 2, vecs[i].ir, vecs[i].dr, vecs[i].cap, vecs[i].exp_rsp, vecs[i].exp_hold);

      for (int i = 0; i < 5; i++) begin
         r = {$urandom(), $urandom()}; rdr = r[DRW-1:0];
         r = {$urandom(), $urandom()}; rcap = r[DRW-1:0];
         rir = IRW'($urandom_range(0, 3));
         scan_check(0, 2, rir, rdr, rcap, rcap, rdr);
      end

      // Back-to-back: cmd_valid stays high across two commands
      r = {$urandom(), $urandom()}; dr_a = r[DRW-1:0];
      r = {$urandom(), $urandom()}; cap_a = r[DRW-1:0];
      r = {$urandom(), $urandom()}; dr_b = r[DRW-1:0];
      r = {$urandom(), $urandom()}; cap_b = r[DRW-1:0];
      udr0 = udr_cnt[0];
      wait_ready(0);
      cap_val[0] = cap_a; cmd_ir[0] = 2'b11; cmd_dr[0] = dr_a; cmd_valid[0] = 1'b1;
      step();
      cmd_ir[0] = 2'b10; cmd_dr[0] = dr_b;
      monitor(0, 2, 2'b11);
      lat1 = lat;
      check("b2b first latency", 64'(lat1), 64'd168);
      check("b2b first rsp_dr", 64'(rsp_dr[0]), 64'(cap_a));
      check("b2b first waveform_faults", 64'(viol), 64'd0);
      cap_val[0] = cap_b;
      step();
      cmd_valid[0] = 1'b0;
      monitor(0, 2, 2'b10);
      check("b2b second rsp cycle", 64'(lat1 + lat), 64'd336);
      check("b2b second rsp_dr", 64'(rsp_dr[0]), 64'(cap_b));
      check("b2b second waveform_faults", 64'(viol), 64'd0);
      step();
      check("b2b slave_at_udr", 64'(held[0]), 64'(dr_b));
      check("b2b udr_pulses", 64'(udr_cnt[0] - udr0), 64'd2);

      // Reset in the middle of SHIFT
      udr0 = udr_cnt[0];
      start(0, 2'b01, 38'h2A5555AAAA, 38'h3F00001234);
      for (int c = 1; c < 60; c++) step();
      check("abort in shift", 64'(sdr[0]), 64'd1);
      rst[0] = 1'b1;
      step();
      check("abort vji outputs", {55'd0, tck[0], tdi[0], ir_in[0], uir[0], cdr[0], sdr[0], udr[0], rti[0]}, 64'd0);
      check("abort cmd_ready/rsp_valid", {62'd0, cmd_ready[0], rsp_valid[0]}, 64'd0);
      check("abort rsp_dr", 64'(rsp_dr[0]), 64'd0);
      seen = 0;
      repeat (2) begin
         step();
         if (rsp_valid[0] || udr[0]) seen++;
      end
      rst[0] = 1'b0;
      repeat (200) begin
         step();
         if (rsp_valid[0] || udr[0] || tck[0]) seen++;
      end
      check("abort no rsp/udr/tck", 64'(seen), 64'd0);
      check("abort slave udr count", 64'(udr_cnt[0] - udr0), 64'd0);
      scan_check(0, 2, vecs[0].ir, vecs[0].dr, vecs[0].cap, vecs[0].exp_rsp, vecs[0].exp_hold);

      // TCK_HALF=1 instance
      scan_check(1, 1, vecs[0].ir, vecs[0].dr, vecs[0].cap, vecs[0].exp_rsp, vecs[0].exp_hold);
      for (int i = 0; i < 3; i++) begin
         r = {$urandom(), $urandom()}; rdr = r[DRW-1:0];
         r = {$urandom(), $urandom()}; rcap = r[DRW-1:0];
         rir = IRW'($urandom_range(0, 3));
         scan_check(1, 1, rir, rdr, rcap, rcap, rdr);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
